pe1x1_ctrl: RTL and testbench

Sequencer for the 1x1-convolution PE row. On a start pulse it walks every (tile, output channel, input channel) triple of a layer. For each triple it issues one feature-map read address and one weight read address, drives the PE `active` enable, and tags the PE results for the downstream accumulator with first/last/channel markers. It sits between the layer-level scheduler (start/done) and the fmap/weight buffers plus the pe1x1 datapath.

---
 rtl/pe1x1_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pe1x1_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pe1x1_ctrl.sv
// pe1x1_ctrl: layer sequencer for the 1x1-convolution PE row.
// Walks (tile, oc, ic) with ic innermost and tile outermost, issuing one
// fmap/weight read per triple. The read results are tagged for the downstream
// accumulator through a two-stage pipeline that follows the buffer read
// latency and the PE register latency.
module pe1x1_ctrl #(
  parameter int CW = 8,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] cfg_ic,
  input  logic [CW-1:0] cfg_oc,
  input  logic [CW-1:0] cfg_tiles,
  input  logic          hold,
  output logic          rd_en,
  output logic [AW-1:0] fmap_addr,
  output logic [AW-1:0] wht_addr,
  output logic          pe_active,
  output logic          acc_vld,
  output logic          acc_first,
  output logic          acc_last,
  output logic [CW-1:0] acc_oc,
  output logic [CW-1:0] acc_tile,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] n_ic, n_oc, n_tiles;   // configuration latched on start
  logic [CW-1:0] ic, oc, tile;          // loop counters
  logic [AW-1:0] fbase, wbase;          // tile*n_ic and oc*n_ic, kept incrementally
  logic          drain_cnt;

  // Stage-1 tags, aligned with pe_active
  logic          s1_first, s1_last;
  logic [CW-1:0] s1_oc, s1_tile;

  logic          issue;
  logic          ic_wrap, oc_wrap, tile_wrap;
  logic          cfg_zero;
  logic [AW-1:0] ic_step;

  // An issue happens in every RUN cycle that is not held back
  assign issue     = (state == S_RUN) && !hold;
  assign ic_wrap   = (ic   == n_ic    - CW'(1));
  assign oc_wrap   = (oc   == n_oc    - CW'(1));
  assign tile_wrap = (tile == n_tiles - CW'(1));
  assign cfg_zero  = (cfg_ic == '0) || (cfg_oc == '0) || (cfg_tiles == '0);
  assign ic_step   = AW'(n_ic);

  assign rd_en     = issue;
  assign fmap_addr = fbase + AW'(ic);
  assign wht_addr  = wbase + AW'(ic);
  assign busy      = (state == S_RUN) || (state == S_DRAIN);
  assign done      = (state == S_DONE);

  // Control FSM: config latch, loop counters and incremental address bases
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state     <= S_IDLE;
      n_ic      <= '0;
      n_oc      <= '0;
      n_tiles   <= '0;
      ic        <= '0;
      oc        <= '0;
      tile      <= '0;
      fbase     <= '0;
      wbase     <= '0;
      drain_cnt <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            n_ic    <= cfg_ic;
            n_oc    <= cfg_oc;
            n_tiles <= cfg_tiles;
            ic      <= '0;
            oc      <= '0;
            tile    <= '0;
            fbase   <= '0;
            wbase   <= '0;
            state   <= cfg_zero ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (issue) begin
            if (!ic_wrap) begin
              ic <= ic + CW'(1);
            end else begin
              ic <= '0;
              if (!oc_wrap) begin
                oc    <= oc + CW'(1);
                wbase <= wbase + ic_step;
              end else begin
                oc    <= '0;
                wbase <= '0;
                if (!tile_wrap) begin
                  tile  <= tile + CW'(1);
                  fbase <= fbase + ic_step;
                end else begin
                  // Last issue of the layer: park counters at zero
                  tile      <= '0;
                  fbase     <= '0;
                  drain_cnt <= 1'b0;
                  state     <= S_DRAIN;
                end
              end
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt) state <= S_DONE;
          drain_cnt <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tag pipeline: stage 1 follows the buffer read, stage 2 follows the PE register
  always_ff @(posedge clk) begin
    // NOTE: synchronous reset clears in-flight tags, so a mid-run reset
    // discards results instead of letting them reach the accumulator.
    if (!rst_n) begin
      pe_active <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_oc     <= '0;
      s1_tile   <= '0;
      acc_vld   <= 1'b0;
      acc_first <= 1'b0;
      acc_last  <= 1'b0;
      acc_oc    <= '0;
      acc_tile  <= '0;
    end else begin
      pe_active <= issue;
      s1_first  <= issue && (ic == '0);
      s1_last   <= issue && ic_wrap;
      s1_oc     <= issue ? oc   : '0;
      s1_tile   <= issue ? tile : '0;
      // Stage-1 tags are already zero on bubbles, so they pass straight through
      acc_vld   <= pe_active;
      acc_first <= s1_first;
      acc_last  <= s1_last;
      acc_oc    <= s1_oc;
      acc_tile  <= s1_tile;
    end
  end

endmodule

// File: tb/tb_pe1x1_ctrl.sv
// Testbench for pe1x1_ctrl: a stimulus task pushes expected issues, results and
// done pulses (with their cycle numbers) into queues; a negedge monitor pops
// and compares whenever the DUT presents rd_en, acc_vld or done.
module tb_pe1x1_ctrl;

  localparam int CW = 8;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] cfg_ic = '0, cfg_oc = '0, cfg_tiles = '0;
  logic          hold = 1'b0;
  logic          rd_en, pe_active, acc_vld, acc_first, acc_last, busy, done;
  logic [AW-1:0] fmap_addr, wht_addr;
  logic [CW-1:0] acc_oc, acc_tile;

  pe1x1_ctrl #(.CW(CW), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cfg_ic    (cfg_ic),
    .cfg_oc    (cfg_oc),
    .cfg_tiles (cfg_tiles),
    .hold      (hold),
    .rd_en     (rd_en),
    .fmap_addr (fmap_addr),
    .wht_addr  (wht_addr),
    .pe_active (pe_active),
    .acc_vld   (acc_vld),
    .acc_first (acc_first),
    .acc_last  (acc_last),
    .acc_oc    (acc_oc),
    .acc_tile  (acc_tile),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [AW-1:0] f;
    logic [AW-1:0] w;
  } iss_t;

  typedef struct {
    int          cyc;
    logic        first;
    logic        last;
    logic [CW-1:0] oc;
    logic [CW-1:0] tile;
  } acc_t;

  iss_t iss_q[$];
  acc_t acc_q[$];
  int   done_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit mon_en  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare every presented output against the queued expectation
  always @(negedge clk) begin
    if (mon_en) begin
      if (rd_en) begin
        if (iss_q.size() == 0) check("unexpected rd_en", 1, 0);
        else begin
          iss_t e;
          e = iss_q.pop_front();
          check("rd_en cycle", cyc, e.cyc);
          check("fmap_addr", fmap_addr, e.f);
          check("wht_addr", wht_addr, e.w);
        end
      end
      if (acc_vld) begin
        if (acc_q.size() == 0) check("unexpected acc_vld", 1, 0);
        else begin
          acc_t a;
          a = acc_q.pop_front();
          check("acc_vld cycle", cyc, a.cyc);
          check("acc_first/last", {acc_first, acc_last}, {a.first, a.last});
          check("acc_oc", acc_oc, a.oc);
          check("acc_tile", acc_tile, a.tile);
        end
      end else begin
        check("acc tags idle", {acc_first, acc_last, acc_oc, acc_tile}, 0);
      end
      if (done) begin
        if (done_q.size() == 0) check("unexpected done", 1, 0);
        else begin
          check("done cycle", cyc, done_q.pop_front());
          check("busy with done", busy, 0);
        end
      end
    end
  end

  // One layer: cycle 0 carries the start pulse; hold is high in cycles
  // hlo..hhi; a second start with another cfg is pulsed in cycle restart_k;
  // rst_n is low in cycle abort_k (0 disables restart/abort).
  task automatic run_layer(input int icn, input int ocn, input int tln,
                           input int hlo, input int hhi,
                           input int restart_k, input int abort_k);
    int c0, k, last, done_k, end_k;
    iss_t is;
    acc_t ac;
    @(posedge clk); #1;
    c0 = cyc;
    start = 1'b1;
    cfg_ic = CW'(icn); cfg_oc = CW'(ocn); cfg_tiles = CW'(tln);
    hold = 1'b0;
    // Expected sequence, built from the loop nest and the hold window
    k = 1;
    last = 0;
    for (int t = 0; t < tln; t++)
      for (int o = 0; o < ocn; o++)
        for (int i = 0; i < icn; i++) begin
          while (k >= hlo && k <= hhi) k++;
          if (abort_k == 0 || k <= abort_k) begin
            is.cyc = c0 + k;
            is.f = AW'(t * icn + i);
            is.w = AW'(o * icn + i);
            iss_q.push_back(is);
          end
          if (abort_k == 0 || k + 2 <= abort_k) begin
            ac.cyc = c0 + k + 2;
            ac.first = (i == 0);
            ac.last = (i == icn - 1);
            ac.oc = CW'(o);
            ac.tile = CW'(t);
            acc_q.push_back(ac);
          end
          last = k;
          k++;
        end
    done_k = (icn == 0 || ocn == 0 || tln == 0) ? 1 : last + 3;
    if (abort_k == 0) done_q.push_back(c0 + done_k);
    end_k = (abort_k != 0) ? abort_k + 4 : done_k + 2;
    for (int j = 1; j <= end_k; j++) begin
      @(posedge clk); #1;
      start = (j == restart_k);
      if (j == restart_k) begin
        cfg_ic = 8'd5; cfg_oc = 8'd5; cfg_tiles = 8'd5;
      end
      hold = (j >= hlo && j <= hhi);
      rst_n = !(abort_k != 0 && j == abort_k);
      if (abort_k != 0 && j == abort_k + 1) begin
        @(negedge clk);
        check("outputs after mid-run reset",
              {rd_en, pe_active, acc_vld, busy, done, fmap_addr, wht_addr,
               acc_first, acc_last, acc_oc, acc_tile}, 0);
      end
    end
    start = 1'b0;
    hold = 1'b0;
    check("missing rd_en issues", iss_q.size(), 0);
    check("missing acc results", acc_q.size(), 0);
    check("missing done", done_q.size(), 0);
    iss_q.delete();
    acc_q.delete();
    done_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset outputs",
          {rd_en, pe_active, acc_vld, busy, done, fmap_addr, wht_addr,
           acc_first, acc_last, acc_oc, acc_tile}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    run_layer(2, 2, 1, 0, -1, 0, 0);   // basic: done in cycle 7
    run_layer(3, 1, 2, 0, -1, 0, 0);   // two tiles
    run_layer(3, 1, 2, 2, 3, 0, 0);    // hold cycles 2-3 shift everything by 2
    run_layer(1, 3, 2, 0, -1, 0, 0);   // ic=1: first and last together
    run_layer(2, 1, 1, 3, 5, 0, 0);    // hold in DRAIN/DONE/IDLE has no effect
    run_layer(2, 0, 3, 0, -1, 1, 0);   // zero cfg, start during DONE ignored
    run_layer(2, 2, 2, 0, -1, 3, 0);   // start mid-run ignored
    run_layer(4, 4, 4, 0, -1, 0, 3);   // reset in cycle 3 aborts
    run_layer(2, 2, 1, 0, -1, 0, 0);   // fresh run after abort

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
